// File: rtl/fib_pkg.sv
// Shared types and seed constants for the Fibonacci-family stream generator.
package fib_pkg;

    typedef enum logic [1:0] {
        FIB    = 2'b00,
        LUCAS  = 2'b01,
        CUSTOM = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int FIB_SEED0   = 0;
    localparam int FIB_SEED1   = 1;
    localparam int LUCAS_SEED0 = 2;
    localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_sat_add.sv
// W-bit adder with carry-out as overflow flag.
// FIB_SATURATE_EN: clamp to all ones on overflow; otherwise wrap modulo 2^W.
module fib_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[W];

`ifdef FIB_SATURATE_EN
    assign sum = ovf ? {W{1'b1}} : full[W-1:0];
`else
    assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/fib_stream_gen.sv
// Streams terms 0..n of a Fibonacci / Lucas / custom-seeded sequence over valid/ready.
// Overflow handling selected by FIB_SATURATE_EN (see fib_sat_add).
module fib_stream_gen
    import fib_pkg::*;
#(
    parameter int W     = 16,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] n,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     seed0,
    input  logic [W-1:0]     seed1,
    input  logic             abort,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             overflow,
    output logic             done
);

    state_e           state;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] n_q;
    logic             b_ovf;
    logic             ovf_q;
    logic [W-1:0]     sum;
    logic             sum_ovf;
    logic             xfer;
    logic             at_last;

    fib_sat_add #(.W(W)) u_add (
        .a   (a),
        .b   (b),
        .sum (sum),
        .ovf (sum_ovf)
    );

    assign at_last = (idx == n_q);
    assign xfer    = (state == RUN) && out_ready;

    // b_ovf remembers whether b came from an overflowing sum; it only
    // reaches the sticky flag once b is promoted into a and emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            idx   <= '0;
            n_q   <= '0;
            b_ovf <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        idx   <= '0;
                        ovf_q <= 1'b0;
                        b_ovf <= 1'b0;
                        case (mode)
                            LUCAS: begin
                                a <= W'(LUCAS_SEED0);
                                b <= W'(LUCAS_SEED1);
                            end
                            CUSTOM: begin
                                a <= seed0;
                                b <= seed1;
                            end
                            default: begin
                                a <= W'(FIB_SEED0);
                                b <= W'(FIB_SEED1);
                            end
                        endcase
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (xfer && !at_last) begin
                        a     <= b;
                        b     <= sum;
                        b_ovf <= sum_ovf;
                        ovf_q <= ovf_q | b_ovf;
                        idx   <= idx + 1'b1;
                    end
                    if (abort) begin
                        state <= IDLE;
                    end else if (xfer && at_last) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign out_valid = (state == RUN);
    assign done      = (state == DONE);
    assign out_data  = a;
    assign out_idx   = idx;
    assign out_last  = out_valid && at_last;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: table of jobs plus hand-written corner sequences.
module tb_fib_stream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  n = '0;
    logic [1:0]  mode = '0;
    logic [15:0] seed0 = '0;
    logic [15:0] seed1 = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        ready16, out_valid16, out_last16, overflow16, done16;
    logic [15:0] out_data16;
    logic [5:0]  out_idx16;
    logic        ready8, out_valid8, out_last8, overflow8, done8;
    logic [7:0]  out_data8;
    logic [5:0]  out_idx8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fib_stream_gen #(.W(16), .IDX_W(6)) dut16 (
        .clk(clk), .rst(rst), .start(start), .n(n), .mode(mode),
        .seed0(seed0), .seed1(seed1), .abort(abort), .ready(ready16),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_idx(out_idx16), .out_last(out_last16), .overflow(overflow16), .done(done16)
    );

    fib_stream_gen #(.W(8), .IDX_W(6)) dut8 (
        .clk(clk), .rst(rst), .start(start), .n(n), .mode(mode),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .abort(abort), .ready(ready8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_idx(out_idx8), .out_last(out_last8), .overflow(overflow8), .done(done8)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [5:0]  n;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [7:0]  off;
        logic        rnd;
    } job_t;

    job_t jobs [5];
    int   exp_terms [0:27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input job_t j);
        int k;
        int cyc;
        check("ready_before_start", 32'(ready16), 1);
        mode = j.mode; n = j.n; seed0 = j.s0; seed1 = j.s1;
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        check("first_valid_latency", 32'(out_valid16), 1);
        k = 0; cyc = 0;
        while (k <= int'(j.n) && cyc < 500) begin
            out_ready = j.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #2;
            check("valid_in_run", 32'(out_valid16), 1);
            check("term_data", 32'(out_data16), 32'(exp_terms[int'(j.off) + k]));
            check("term_idx", 32'(out_idx16), 32'(k));
            check("term_last", 32'(out_last16), 32'(k == int'(j.n)));
            if (out_valid16 && out_ready) k++;
            tick();
            cyc++;
        end
        if (cyc >= 500) begin
            miscompares++;
            $display("FAIL job_timeout: got %0d terms expected %0d", k, int'(j.n) + 1);
        end
        out_ready = 1'b0;
        check("done_pulse", 32'(done16), 1);
        check("done_valid_low", 32'(out_valid16), 0);
        check("done_ready_low", 32'(ready16), 0);
        check("job_overflow", 32'(overflow16), 0);
        tick();
        check("done_clears", 32'(done16), 0);
        check("ready_returns", 32'(ready16), 1);
    endtask

    initial begin
        logic [7:0] e14;
        logic [7:0] e15;
        int cyc;

        exp_terms = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
                      987, 1597, 2584, 4181, 6765, 2, 1, 3, 4, 7, 11, 5};
        jobs[0] = '{mode: 2'b00, n: 6'd20, s0: 16'd0, s1: 16'd0, off: 8'd0,  rnd: 1'b0};
        jobs[1] = '{mode: 2'b01, n: 6'd5,  s0: 16'd0, s1: 16'd0, off: 8'd21, rnd: 1'b0};
        jobs[2] = '{mode: 2'b00, n: 6'd20, s0: 16'd0, s1: 16'd0, off: 8'd0,  rnd: 1'b1};
        jobs[3] = '{mode: 2'b10, n: 6'd0,  s0: 16'd5, s1: 16'd9, off: 8'd27, rnd: 1'b0};
        jobs[4] = '{mode: 2'b11, n: 6'd6,  s0: 16'd7, s1: 16'd7, off: 8'd0,  rnd: 1'b0};
`ifdef FIB_SATURATE_EN
        e14 = 8'd255; e15 = 8'd255;
`else
        e14 = 8'd121; e15 = 8'd98;
`endif

        // Reset state
        #1;
        check("rst_ready", 32'(ready16), 1);
        check("rst_valid", 32'(out_valid16), 0);
        check("rst_data", 32'(out_data16), 0);
        check("rst_idx", 32'(out_idx16), 0);
        check("rst_last", 32'(out_last16), 0);
        check("rst_overflow", 32'(overflow16), 0);
        check("rst_done", 32'(done16), 0);
        #12 rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Start during RUN must be ignored
        mode = 2'b00; n = 6'd5; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k == 2) begin
                start = 1'b1; mode = 2'b01; n = 6'd1;
            end
            #2;
            check("ign_data", 32'(out_data16), 32'(exp_terms[k]));
            check("ign_idx", 32'(out_idx16), 32'(k));
            check("ign_last", 32'(out_last16), 32'(k == 5));
            tick();
            start = 1'b0;
        end
        check("ign_done", 32'(done16), 1);
        tick();
        check("ign_ready", 32'(ready16), 1);

        // W=8 Fibonacci n=15: overflow appears only once F14 is emitted
        mode = 2'b00; n = 6'd15; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            #2;
            check("w8_valid", 32'(out_valid8), 1);
            check("w8_data", 32'(out_data8),
                  (k == 14) ? 32'(e14) : (k == 15) ? 32'(e15) : 32'(exp_terms[k]));
            check("w8_idx", 32'(out_idx8), 32'(k));
            check("w8_overflow", 32'(overflow8), 32'(k >= 14));
            tick();
        end
        check("w8_done", 32'(done8), 1);
        check("w8_overflow_sticky", 32'(overflow8), 1);
        tick();

        // Abort at idx 7
        mode = 2'b00; n = 6'd20; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (out_idx16 !== 6'd7 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("abort_reach_idx7", 32'(out_idx16), 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid_low", 32'(out_valid16), 0);
        check("abort_ready", 32'(ready16), 1);
        check("abort_no_done", 32'(done16), 0);
        check("abort_overflow_hold", 32'(overflow16), 0);
        tick();
        check("abort_no_done_later", 32'(done16), 0);

        // Asynchronous reset mid-job at idx 3
        mode = 2'b00; n = 6'd20; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (out_idx16 !== 6'd3 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("rst_reach_idx3", 32'(out_idx16), 3);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid16), 0);
        check("midrst_ready", 32'(ready16), 1);
        check("midrst_data", 32'(out_data16), 0);
        check("midrst_idx", 32'(out_idx16), 0);
        check("midrst_last", 32'(out_last16), 0);
        check("midrst_done", 32'(done16), 0);
        tick();
        #2 rst = 1'b1;
        tick();
        run_job(jobs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fib_stream_gen.md
# fib_stream_gen

Parametrised, streaming successor to the single-result Fibonacci unit. On a start request it generates terms 0..n of a second-order additive sequence: Fibonacci, Lucas or user-seeded. Terms are emitted one per handshake on a valid/ready output stream, with index, last-term marker, overflow detection and abort. It sits between control logic that issues jobs and any downstream consumer that can apply backpressure.

## Interface
Parameters:
- W, 16, term data width in bits (≥ 4)
- IDX_W, 6, term-index width; max n = 2^IDX_W − 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request, accepted only when ready=1
- n  in  IDX_W  index of the last term to emit
- mode  in  2  00 Fibonacci, 01 Lucas, 10 custom seeds, 11 treated as 00
- seed0  in  W  term 0, mode 10 only
- seed1  in  W  term 1, mode 10 only
- abort  in  1  cancel the running job
- ready  out  1  idle; a start will be accepted this cycle
- out_valid  out  1  out_data/out_idx/out_last are valid
- out_ready  in  1  consumer accepts the current term
- out_data  out  W  current term
- out_idx  out  IDX_W  index of the current term
- out_last  out  1  out_idx == captured n
- overflow  out  1  sticky per job; an addition exceeded 2^W − 1
- done  out  1  one-cycle pulse on job completion

## Operation
- FSM states: IDLE, RUN, DONE. The state type is a package enum.
- IDLE: ready=1. start=1 captures n, mode and seeds, clears overflow, loads the pair (a,b) and sets idx=0, then goes to RUN.
- Seeds: Fibonacci (0,1); Lucas (2,1); custom (seed0,seed1).
- RUN: out_valid=1, out_data=a, out_idx=idx.
  - On out_valid & out_ready with idx≠n: a←b, b←a+b, idx←idx+1.
  - On out_valid & out_ready with idx==n: go to DONE.
- DONE: lasts one cycle with done=1, out_valid=0 and ready=0, then returns to IDLE.
- abort in RUN: return to IDLE next cycle. out_valid drops, no done pulse, overflow holds its value. If abort and a handshake occur in the same cycle, the term counts as transferred and abort wins, so there is no DONE.
- start while not IDLE is ignored. Inputs captured at acceptance are frozen for the job.
- n=0: a single term, term 0 (seed0 in custom mode), with out_last=1.
- Addition is computed W+1 bits wide; bit W set means overflow. overflow is sticky until the next accepted start.
- The addition is evaluated for b's successor even when that term is never emitted. Overflow is therefore flagged only for sums that are actually loaded into a.
- Reset values: IDLE, ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0, done=0.
- Asserting rst at any time, including mid-job, forces these values immediately. No partial job resumes.

## Timing
- Start-to-first-term latency is 1 cycle: start accepted at edge k gives out_valid=1 after edge k.
- Throughput is 1 term/cycle when out_ready is held at 1. Job length is n+1 cycles in RUN plus 1 cycle in DONE.
- While out_valid=1 and out_ready=0: out_data, out_idx and out_last hold stable.
- done rises the cycle after the last handshake. ready returns one cycle after that.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready to out_valid.

## Configuration
- FIB_SATURATE_EN defined: on overflow, the new term saturates to all ones (2^W − 1), later sums also saturate, and overflow=1.
- FIB_SATURATE_EN undefined: sums wrap modulo 2^W, and overflow=1 is still reported.

## Structure
- Package fib_pkg contains:
  - mode_e with FIB, LUCAS, CUSTOM
  - state_e with IDLE, RUN, DONE
  - constants FIB_SEED0=0, FIB_SEED1=1, LUCAS_SEED0=2, LUCAS_SEED1=1
- Sub-module fib_sat_add (parameter W): inputs a, b; outputs sum and ovf. It contains the FIB_SATURATE_EN logic.

## Test plan
- Fibonacci, W=16, n=20, out_ready=1 → 21 consecutive terms 0,1,1,2,…,4181,6765 with idx 0..20; out_last only at 6765; done pulse; overflow=0.
- Lucas, n=5 → 2,1,3,4,7,11; then 11 carries out_last=1.
- Fibonacci n=20 with out_ready randomised per cycle → same 21-term sequence; data held stable on every stalled cycle; no drops or duplicates.
- W=8, Fibonacci, n=15 → F13=233. F14 onward:
  - with FIB_SATURATE_EN: all terms = 255, overflow=1
  - without FIB_SATURATE_EN: F14 = 377 mod 256 = 121, overflow=1
- Custom seeds 5,9 with n=0 → single term 5 with out_last=1, done one cycle later; start asserted during RUN of the next job is ignored.
- abort at idx=7 → IDLE next cycle, no done. rst low at idx=3 of a new job → all outputs reset immediately; a subsequent start restarts from idx 0.
